// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with optional even parity. One frame per debounced-free
// rising edge of btn1; payload latched from sw at acceptance.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic [7:0] sw,
  output logic       onebit_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] led
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic        btn_s1_q, btn_s1_d;
  logic        btn_s2_q, btn_s2_d;
  logic        btn_prev_q, btn_prev_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        line_q, line_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  led_q, led_d;

  logic req;
  logic baud_wrap;

  assign req       = btn_s2_q & ~btn_prev_q;
  assign baud_wrap = (baud_q == BAUD_MAX);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    btn_s1_d   = btn1;
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    line_d     = line_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    led_d      = led_q;

    // The line value is computed for the state being entered, so the output
    // flop switches on the same edge as the state.
    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        baud_d = '0;
        if (req) begin
          state_d   = START;
          shift_d   = sw;
          led_d     = sw;
          parity_d  = ^sw;
          busy_d    = 1'b1;
          bit_idx_d = '0;
          line_d    = 1'b0;
        end
      end
      START: begin
        baud_d = baud_wrap ? '0 : baud_q + 16'd1;
        if (baud_wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
          line_d    = shift_q[0];
        end
      end
      DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + 16'd1;
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              line_d  = parity_q;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            line_d    = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        baud_d = baud_wrap ? '0 : baud_q + 16'd1;
        if (baud_wrap) begin
          state_d = STOP;
          line_d  = 1'b1;
        end
      end
      STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + 16'd1;
        if (baud_wrap) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          line_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous and overrides every other update, including mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign onebit_data = line_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign led         = led_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a no-parity and an even-parity instance side by
// side, with a frame-decoding monitor checking every line sample against a queue.
module tb_uart_transmitter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn;
  logic [7:0] sw;
  logic [1:0] line;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] led0, led1;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn1(btn[0]), .sw(sw),
    .onebit_data(line[0]), .busy(busy[0]), .done(done[0]), .led(led0)
  );

  uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn1(btn[1]), .sw(sw),
    .onebit_data(line[1]), .busy(busy[1]), .done(done[1]), .led(led1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];

  bit          mon_active[2] = '{0, 0};
  bit          mon_chk[2]    = '{0, 0};
  bit          mon_end[2]    = '{0, 0};
  int          mon_pos[2]    = '{0, 0};
  logic [10:0] mon_bits[2];
  logic [7:0]  mon_rx[2];
  logic        mon_par[2]    = '{1'b0, 1'b0};
  logic [7:0]  rx_byte[2]    = '{8'h00, 8'h00};
  int          frames_rx[2]  = '{0, 0};
  int          done_cnt[2]   = '{0, 0};
  logic [7:0]  mon_eb;

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (par) f[9] = ^b;
    return f;
  endfunction

  // Receiver model: samples the line every cycle on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mon_active[k] = 1'b0;
        mon_end[k]    = 1'b0;
      end else begin
        if (done[k] === 1'b1) done_cnt[k]++;
        if (mon_end[k]) begin
          mon_end[k] = 1'b0;
          n_checks++;
          if (done[k] !== 1'b1 || busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end dut%0d: done=%b busy=%b, want done=1 busy=0", k, done[k], busy[k]);
          end
        end
        if (!mon_active[k] && line[k] === 1'b0) begin
          mon_active[k] = 1'b1;
          mon_pos[k]    = 0;
          mon_chk[k]    = 1'b1;
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            mon_chk[k] = 1'b0;
            $display("FAIL unexpected_frame dut%0d: start bit seen, want no frame", k);
            mon_eb = 8'h00;
          end else if (k == 0) begin
            mon_eb = exp_q0.pop_front();
          end else begin
            mon_eb = exp_q1.pop_front();
          end
          mon_bits[k] = frame_bits(mon_eb, k == 1);
        end
        if (mon_active[k]) begin
          if (mon_chk[k]) begin
            n_checks++;
            if (line[k] !== mon_bits[k][mon_pos[k] / N] || busy[k] !== 1'b1) begin
              n_fail++;
              $display("FAIL frame_bit dut%0d pos %0d: line=%b busy=%b, want line=%b busy=1",
                       k, mon_pos[k], line[k], busy[k], mon_bits[k][mon_pos[k] / N]);
            end
          end
          if (mon_pos[k] % N == N / 2) begin
            if (mon_pos[k] / N >= 1 && mon_pos[k] / N <= 8) mon_rx[k][mon_pos[k] / N - 1] = line[k];
            if (mon_pos[k] / N == 9 && k == 1) mon_par[k] = line[k];
          end
          mon_pos[k]++;
          if (mon_pos[k] == (k == 1 ? 11 : 10) * N) begin
            mon_active[k] = 1'b0;
            mon_end[k]    = 1'b1;
            frames_rx[k]++;
            rx_byte[k]    = mon_rx[k];
          end
        end
      end
    end
  end

  // Shared stimulus: press both buttons with payload b and count busy cycles.
  task automatic send_frame(input logic [7:0] b, input int hold, input int extra_at,
                            output int bc0, output int bc1);
    @(negedge clk);
    sw  = b;
    btn = 2'b11;
    exp_q0.push_back(b);
    exp_q1.push_back(b);
    bc0 = 0;
    bc1 = 0;
    for (int i = 1; i <= hold + 60; i++) begin
      @(negedge clk);
      bc0 += int'(busy[0]);
      bc1 += int'(busy[1]);
      if (i == hold) btn = 2'b00;
      if (extra_at > 0 && i == extra_at) begin
        sw  = ~b;
        btn = 2'b11;
      end
      if (extra_at > 0 && i == extra_at + 2) btn = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 2'b00;
    sw    = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn = ~btn;
      n_checks++;
      if (line !== 2'b11 || busy !== 2'b00 || done !== 2'b00 || led0 !== 8'h00 || led1 !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: line=%b busy=%b done=%b led0=%h led1=%h, want 11 00 00 00 00",
                 i, line, busy, done, led0, led1);
      end
    end
    btn = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (line !== 2'b11 || busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: line=%b busy=%b, want 11 00", i, line, busy);
      end
    end
    n_checks++;
    if (frames_rx[0] != 0 || frames_rx[1] != 0 || done_cnt[0] != 0 || done_cnt[1] != 0) begin
      n_fail++;
      $display("FAIL reset_no_frame: frames=%0d/%0d dones=%0d/%0d, want 0", frames_rx[0], frames_rx[1],
               done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_basic();
    int bc0, bc1, f0, f1, d0, d1;
    f0 = frames_rx[0]; f1 = frames_rx[1];
    d0 = done_cnt[0];  d1 = done_cnt[1];
    bc0 = 0; bc1 = 0;
    @(negedge clk);
    sw  = 8'hA5;
    btn = 2'b11;
    exp_q0.push_back(8'hA5);
    exp_q1.push_back(8'hA5);
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      bc0 += int'(busy[0]);
      bc1 += int'(busy[1]);
      if (i == 2) begin
        n_checks++;
        if (line !== 2'b11) begin
          n_fail++;
          $display("FAIL latency_early: line=%b after 2 edges, want 11", line);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (line !== 2'b00) begin
          n_fail++;
          $display("FAIL latency_start: line=%b after 3 edges, want 00", line);
        end
        btn = 2'b00;
      end
    end
    n_checks++;
    if (bc0 != 40 || bc1 != 44) begin
      n_fail++;
      $display("FAIL busy_length: %0d/%0d cycles, want 40/44", bc0, bc1);
    end
    n_checks++;
    if (done_cnt[0] - d0 != 1 || done_cnt[1] - d1 != 1 || frames_rx[0] - f0 != 1 || frames_rx[1] - f1 != 1) begin
      n_fail++;
      $display("FAIL basic_counts: dones %0d/%0d frames %0d/%0d, want 1 each", done_cnt[0] - d0,
               done_cnt[1] - d1, frames_rx[0] - f0, frames_rx[1] - f1);
    end
    n_checks++;
    if (led0 !== 8'hA5 || led1 !== 8'hA5 || rx_byte[0] !== 8'hA5 || rx_byte[1] !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_data: led=%h/%h rx=%h/%h, want a5", led0, led1, rx_byte[0], rx_byte[1]);
    end
  endtask

  task automatic test_parity();
    int bc0, bc1;
    send_frame(8'h07, 2, 0, bc0, bc1);
    n_checks++;
    if (mon_par[1] !== 1'b1 || bc1 != 44) begin
      n_fail++;
      $display("FAIL parity_07: parity=%b busy=%0d, want 1 and 44", mon_par[1], bc1);
    end
    send_frame(8'h03, 2, 0, bc0, bc1);
    n_checks++;
    if (mon_par[1] !== 1'b0 || bc1 != 44 || bc0 != 40) begin
      n_fail++;
      $display("FAIL parity_03: parity=%b busy=%0d/%0d, want 0 and 40/44", mon_par[1], bc0, bc1);
    end
  endtask

  task automatic test_held_button();
    int bc0, bc1, f0, f1, d0, d1;
    f0 = frames_rx[0]; f1 = frames_rx[1];
    d0 = done_cnt[0];  d1 = done_cnt[1];
    send_frame(8'hC3, 200, 0, bc0, bc1);
    n_checks++;
    if (frames_rx[0] - f0 != 1 || frames_rx[1] - f1 != 1 || done_cnt[0] - d0 != 1 || done_cnt[1] - d1 != 1
        || bc0 != 40 || bc1 != 44) begin
      n_fail++;
      $display("FAIL held_button: frames %0d/%0d dones %0d/%0d busy %0d/%0d, want 1/1 1/1 40/44",
               frames_rx[0] - f0, frames_rx[1] - f1, done_cnt[0] - d0, done_cnt[1] - d1, bc0, bc1);
    end
  endtask

  task automatic test_busy_press();
    int bc0, bc1, f0, f1, d0, d1;
    f0 = frames_rx[0]; f1 = frames_rx[1];
    d0 = done_cnt[0];  d1 = done_cnt[1];
    send_frame(8'h5A, 2, 15, bc0, bc1);
    n_checks++;
    if (frames_rx[0] - f0 != 1 || frames_rx[1] - f1 != 1 || done_cnt[0] - d0 != 1 || done_cnt[1] - d1 != 1) begin
      n_fail++;
      $display("FAIL busy_press: frames %0d/%0d dones %0d/%0d, want 1 each", frames_rx[0] - f0,
               frames_rx[1] - f1, done_cnt[0] - d0, done_cnt[1] - d1);
    end
    n_checks++;
    if (led0 !== 8'h5A || led1 !== 8'h5A || rx_byte[0] !== 8'h5A || rx_byte[1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL sw_immunity: led=%h/%h rx=%h/%h, want 5a", led0, led1, rx_byte[0], rx_byte[1]);
    end
  endtask

  task automatic test_back_to_back();
    int f0, f1;
    f0 = frames_rx[0]; f1 = frames_rx[1];
    @(negedge clk);
    sw  = 8'h81;
    btn = 2'b11;
    exp_q0.push_back(8'h81);
    exp_q1.push_back(8'h81);
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (i == 2) btn = 2'b00;
      if (i == 41) begin
        sw     = 8'h7E;
        btn[0] = 1'b1;
        exp_q0.push_back(8'h7E);
      end
      if (i == 43) begin
        n_checks++;
        if (done[0] !== 1'b1 || line[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done0: done=%b line=%b, want 1 1", done[0], line[0]);
        end
      end
      if (i == 44) begin
        n_checks++;
        if (line[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_start0: line=%b, want 0", line[0]);
        end
      end
      if (i == 45) begin
        btn[1] = 1'b1;
        exp_q1.push_back(8'h7E);
      end
      if (i == 47) begin
        n_checks++;
        if (done[1] !== 1'b1 || line[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done1: done=%b line=%b, want 1 1", done[1], line[1]);
        end
      end
      if (i == 48) begin
        n_checks++;
        if (line[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_start1: line=%b, want 0", line[1]);
        end
      end
      if (i == 50) btn = 2'b00;
    end
    n_checks++;
    if (frames_rx[0] - f0 != 2 || frames_rx[1] - f1 != 2 || led0 !== 8'h7E || led1 !== 8'h7E) begin
      n_fail++;
      $display("FAIL b2b_counts: frames %0d/%0d led %h/%h, want 2/2 7e/7e", frames_rx[0] - f0,
               frames_rx[1] - f1, led0, led1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bc0, bc1, f0, f1;
    f0 = frames_rx[0]; f1 = frames_rx[1];
    @(negedge clk);
    sw  = 8'h96;
    btn = 2'b11;
    exp_q0.push_back(8'h96);
    exp_q1.push_back(8'h96);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 2) btn = 2'b00;
      if (i == 20) rst_n = 1'b0;
    end
    n_checks++;
    if (line !== 2'b11 || busy !== 2'b00 || led0 !== 8'h00 || led1 !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: line=%b busy=%b led=%h/%h, want 11 00 00/00", line, busy, led0, led1);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h96, 2, 0, bc0, bc1);
    n_checks++;
    if (frames_rx[0] - f0 != 1 || frames_rx[1] - f1 != 1 || rx_byte[0] !== 8'h96 || rx_byte[1] !== 8'h96
        || bc0 != 40 || bc1 != 44) begin
      n_fail++;
      $display("FAIL after_reset: frames %0d/%0d rx %h/%h busy %0d/%0d, want 1/1 96/96 40/44",
               frames_rx[0] - f0, frames_rx[1] - f1, rx_byte[0], rx_byte[1], bc0, bc1);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] pat[3] = '{8'h00, 8'hFF, 8'h3C};
    int bc0, bc1;
    for (int j = 0; j < 3; j++) begin
      send_frame(pat[j], 2, 0, bc0, bc1);
      n_checks++;
      if (rx_byte[0] !== pat[j] || rx_byte[1] !== pat[j] || led0 !== pat[j]) begin
        n_fail++;
        $display("FAIL loopback: rx=%h/%h led=%h, want %h", rx_byte[0], rx_byte[1], led0, pat[j]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 2'b00;
    sw    = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_held_button();
    test_busy_press();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0 || mon_active[0] || mon_active[1]) begin
      n_fail++;
      $display("FAIL drain: pending %0d/%0d active %0d/%0d, want all 0", exp_q0.size(), exp_q1.size(),
               mon_active[0], mon_active[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
